// File: rtl/rf_pkg.sv
// Shared register-file geometry and write-port types used by the register file,
// the pipeline and the writeback arbiter.
package rf_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam int NREG   = 32;

  typedef logic [REG_W-1:0]  reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  // One registered drive of the register-file write port.
  typedef struct packed {
    logic      wr;
    reg_addr_t a3;
    reg_data_t wd;
  } rf_wr_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard for multi-cycle destinations: reservation mask,
// hazard lookup for both read ports, and a sticky unreserved-write error flag.
module rf_scoreboard
  import rf_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      en_i,
  input  logic      rsv_vld_i,
  input  reg_addr_t rsv_reg_i,
  input  logic      clr_vld_i,
  input  reg_addr_t clr_reg_i,
  input  logic      rf_wr_i,
  input  reg_addr_t rf_a3_i,
  input  reg_addr_t q1_reg_i,
  input  reg_addr_t q2_reg_i,
  output logic      q1_busy_o,
  output logic      q2_busy_o,
  output logic      sb_err_o
);

  logic [NREG-1:0] pend_q, pend_d;
  logic            err_q, err_d;

  // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    pend_d = pend_q;
    err_d  = err_q;
    if (clr_vld_i) begin
      pend_d[clr_reg_i] = 1'b0;
      if (clr_reg_i != '0 && !pend_q[clr_reg_i]) err_d = 1'b1;
    end
    // The set is applied after the clear so a same-cycle reservation wins.
    if (rsv_vld_i) pend_d[rsv_reg_i] = 1'b1;
    pend_d[0] = 1'b0;
  end

  // NOTE: non-blocking assignments for all state; the async reset clears the whole mask.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      err_q  <= 1'b0;
    end else if (en_i) begin
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

  // An in-flight write on the register-file port still counts as busy for one cycle.
  assign q1_busy_o = (q1_reg_i != '0) && (pend_q[q1_reg_i] || (rf_wr_i && rf_a3_i == q1_reg_i));
  assign q2_busy_o = (q2_reg_i != '0) && (pend_q[q2_reg_i] || (rf_wr_i && rf_a3_i == q2_reg_i));
  assign sb_err_o  = err_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Two-port writeback arbiter onto the single register-file write port: pipeline
// port 0 has priority until multi-cycle port 1 has been refused STARVE_MAX times.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb0_vld,
  output logic              wb0_rdy,
  input  logic [REG_W-1:0]  wb0_reg,
  input  logic [DATA_W-1:0] wb0_data,
  input  logic              wb1_vld,
  output logic              wb1_rdy,
  input  logic [REG_W-1:0]  wb1_reg,
  input  logic [DATA_W-1:0] wb1_data,
  input  logic              rsv_vld,
  input  logic [REG_W-1:0]  rsv_reg,
  input  logic [REG_W-1:0]  q1_reg,
  input  logic [REG_W-1:0]  q2_reg,
  output logic              q1_busy,
  output logic              q2_busy,
  output logic              rf_wr,
  output logic [REG_W-1:0]  rf_a3,
  output logic [DATA_W-1:0] rf_wd,
  output logic              sb_err
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_q, starve_d;
  logic       armed_q;
  rf_wr_t     wr_q, wr_d;
  logic       at_limit, xfer0, xfer1;

  assign at_limit = (starve_q == STARVE_LIM);
  assign wb0_rdy  = at_limit ? !wb1_vld : 1'b1;
  assign wb1_rdy  = at_limit ? 1'b1     : !wb0_vld;
  assign xfer0    = wb0_vld && wb0_rdy;
  assign xfer1    = wb1_vld && wb1_rdy;

  always_comb begin
    starve_d = starve_q;
    if (!wb1_vld || xfer1)        starve_d = '0;
    else if (starve_q != STARVE_LIM) starve_d = starve_q + 4'd1;
  end

  // Register 0 handshakes normally but never reaches the register file.
  always_comb begin
    wr_d    = wr_q;
    wr_d.wr = 1'b0;
    if (xfer0 && wb0_reg != '0) begin
      wr_d = '{wr: 1'b1, a3: wb0_reg, wd: wb0_data};
    end else if (xfer1 && wb1_reg != '0) begin
      wr_d = '{wr: 1'b1, a3: wb1_reg, wd: wb1_data};
    end
  end

  // armed_q stays low for the first edge after reset release, so a transfer
  // presented in the release cycle leaves no trace.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q  <= 1'b0;
      starve_q <= '0;
      wr_q     <= '0;
    end else begin
      armed_q <= 1'b1;
      if (armed_q) begin
        starve_q <= starve_d;
        wr_q     <= wr_d;
      end
    end
  end

  rf_scoreboard u_sb (
    .clk       (clk),
    .rst       (rst),
    .en_i      (armed_q),
    .rsv_vld_i (rsv_vld),
    .rsv_reg_i (rsv_reg),
    .clr_vld_i (xfer1),
    .clr_reg_i (wb1_reg),
    .rf_wr_i   (wr_q.wr),
    .rf_a3_i   (wr_q.a3),
    .q1_reg_i  (q1_reg),
    .q2_reg_i  (q2_reg),
    .q1_busy_o (q1_busy),
    .q2_busy_o (q2_busy),
    .sb_err_o  (sb_err)
  );

  assign rf_wr = wr_q.wr;
  assign rf_a3 = wr_q.a3;
  assign rf_wd = wr_q.wd;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: arbitration, starvation limit, scoreboard
// hazards, register-0 writes, sticky error and asynchronous reset.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb0_vld = 1'b0, wb1_vld = 1'b0, rsv_vld = 1'b0;
  logic [4:0]  wb0_reg = '0, wb1_reg = '0, rsv_reg = '0, q1_reg = '0, q2_reg = '0;
  logic [31:0] wb0_data = '0, wb1_data = '0;
  logic        wb0_rdy, wb1_rdy, q1_busy, q2_busy, rf_wr, sb_err;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;

  int n_vec = 0;
  int n_bad = 0;

  rf_wb_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .wb0_vld(wb0_vld), .wb0_rdy(wb0_rdy), .wb0_reg(wb0_reg), .wb0_data(wb0_data),
    .wb1_vld(wb1_vld), .wb1_rdy(wb1_rdy), .wb1_reg(wb1_reg), .wb1_data(wb1_data),
    .rsv_vld(rsv_vld), .rsv_reg(rsv_reg),
    .q1_reg(q1_reg), .q2_reg(q2_reg), .q1_busy(q1_busy), .q2_busy(q2_busy),
    .rf_wr(rf_wr), .rf_a3(rf_a3), .rf_wd(rf_wd), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] r1, input logic [31:0] d1,
                       input logic rv, input logic [4:0] rr);
    wb0_vld = v0; wb0_reg = r0; wb0_data = d0;
    wb1_vld = v1; wb1_reg = r1; wb1_data = d1;
    rsv_vld = rv; rsv_reg = rr;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
  endtask

  initial begin
    // ---------------- reset state ----------------
    #1 rst = 1'b1;
    q1_reg = 5'd5;
    #2;
    check("rst_rf_wr", rf_wr, 0);
    check("rst_rf_a3", rf_a3, 0);
    check("rst_rf_wd", rf_wd, 0);
    check("rst_sb_err", sb_err, 0);
    check("rst_q1_busy", q1_busy, 0);
    @(posedge clk);
    #3 rst = 1'b0;

    // Transfer presented in the release cycle is discarded.
    drive(1'b1, 5'd5, 32'hAA, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    #1 check("rel_wb0_rdy", wb0_rdy, 1);
    tick();
    check("rel_rf_wr", rf_wr, 0);
    check("rel_rf_a3", rf_a3, 0);

    // ---------------- simultaneous requests ----------------
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd6);
    tick();
    q1_reg = 5'd6;
    drive(1'b1, 5'd5, 32'h11, 1'b1, 5'd6, 32'h22, 1'b0, 5'd0);
    #1;
    check("both_q1_busy_r6", q1_busy, 1);
    check("both_wb0_rdy", wb0_rdy, 1);
    check("both_wb1_rdy", wb1_rdy, 0);
    tick();
    check("both_c1_rf_wr", rf_wr, 1);
    check("both_c1_rf_a3", rf_a3, 5);
    check("both_c1_rf_wd", rf_wd, 32'h11);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h22, 1'b0, 5'd0);
    #1 check("both_wb1_rdy_c2", wb1_rdy, 1);
    tick();
    check("both_c2_rf_wr", rf_wr, 1);
    check("both_c2_rf_a3", rf_a3, 6);
    check("both_c2_rf_wd", rf_wd, 32'h22);
    check("both_c2_q1_inflight", q1_busy, 1);
    idle();
    tick();
    check("both_c3_rf_wr", rf_wr, 0);
    check("both_c3_hold_a3", rf_a3, 6);
    check("both_c3_hold_wd", rf_wd, 32'h22);
    check("both_c3_q1_free", q1_busy, 0);

    // ---------------- reservation and hazard query ----------------
    q1_reg = 5'd9;
    q2_reg = 5'd0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
    tick();
    idle();
    #1;
    check("rsv9_q1_busy", q1_busy, 1);
    check("rsv9_q2_busy", q2_busy, 0);
    tick();
    check("rsv9_q1_busy_hold", q1_busy, 1);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0);
    #1 check("rsv9_wb1_rdy", wb1_rdy, 1);
    tick();
    idle();
    #1;
    check("rsv9_rf_a3", rf_a3, 9);
    check("rsv9_q1_inflight", q1_busy, 1);
    check("rsv9_q2_busy_w", q2_busy, 0);
    tick();
    check("rsv9_q1_clear", q1_busy, 0);
    check("rsv9_q2_clear", q2_busy, 0);

    // ---------------- starvation limit ----------------
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 5'd1, 32'h100 + 32'(i), 1'b1, 5'd7, 32'h77, 1'b0, 5'd0);
      #1;
      check($sformatf("stv_wb1_rdy_%0d", i), wb1_rdy, (i == 4) ? 1 : 0);
      check($sformatf("stv_wb0_rdy_%0d", i), wb0_rdy, (i == 4) ? 0 : 1);
      tick();
      check($sformatf("stv_a3_%0d", i), rf_a3, (i == 4) ? 7 : 1);
      check($sformatf("stv_wd_%0d", i), rf_wd, (i == 4) ? 32'h77 : 32'h100 + 32'(i));
    end
    drive(1'b1, 5'd1, 32'h200, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    tick();
    // Starve counter back at 0: a fresh port-1 request is refused immediately.
    drive(1'b1, 5'd1, 32'h201, 1'b1, 5'd0, 32'h0, 1'b0, 5'd0);
    #1;
    check("stv_reset_wb1_rdy", wb1_rdy, 0);
    check("stv_reset_wb0_rdy", wb0_rdy, 1);
    tick();
    idle();
    tick();

    // ---------------- write to register 0 ----------------
    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    #1 check("r0_wb0_rdy", wb0_rdy, 1);
    tick();
    check("r0_rf_wr", rf_wr, 0);
    check("r0_rf_a3", rf_a3, 1);
    check("r0_rf_wd", rf_wd, 32'h201);
    idle();

    // ---------------- same-cycle set/clear and sticky error ----------------
    q1_reg = 5'd3;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd3);
    tick();
    idle();
    #1;
    check("sc_rf_a3", rf_a3, 3);
    check("sc_sb_err", sb_err, 0);
    tick();
    check("sc_pend3_kept", q1_busy, 1);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h44, 1'b0, 5'd0);
    tick();
    idle();
    #1;
    check("err_rf_wr", rf_wr, 1);
    check("err_rf_a3", rf_a3, 4);
    check("err_sb_err", sb_err, 1);
    tick();
    tick();
    check("err_sticky", sb_err, 1);

    // ---------------- asynchronous reset mid-cycle ----------------
    drive(1'b1, 5'd8, 32'h88, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    tick();
    idle();
    check("ar_pre_rf_wr", rf_wr, 1);
    #2 rst = 1'b1;
    #1;
    check("ar_rf_wr", rf_wr, 0);
    check("ar_rf_a3", rf_a3, 0);
    check("ar_rf_wd", rf_wd, 0);
    check("ar_sb_err", sb_err, 0);
    for (int r = 1; r < 32; r += 5) begin
      q1_reg = 5'(r);
      #1 check($sformatf("ar_q1_busy_r%0d", r), q1_busy, 0);
    end
    q1_reg = 5'd3;
    #1 check("ar_q1_busy_r3", q1_busy, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
    check("ar_post_pend3", q1_busy, 0);
    check("ar_post_rf_wr", rf_wr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, meaning the number of consecutive cycles port 1 may be refused before it takes priority (legal 1..15).
REQ-002 SHALL have port clk, input, 1, clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have port wb0_vld, input, 1, pipeline writeback request valid.
REQ-005 SHALL have port wb0_rdy, output, 1, pipeline writeback accepted this cycle when high with wb0_vld.
REQ-006 SHALL have ports wb0_reg (input, 5) and wb0_data (input, 32), carrying the pipeline destination register and write data.
REQ-007 SHALL have ports wb1_vld (input, 1), wb1_rdy (output, 1), wb1_reg (input, 5) and wb1_data (input, 32), forming the same handshake for the multi-cycle unit.
REQ-008 SHALL have ports rsv_vld (input, 1) and rsv_reg (input, 5), reserving a multi-cycle destination register at issue.
REQ-009 SHALL have ports q1_reg and q2_reg (input, 5 each), the hazard query addresses matching the register-file read ports.
REQ-010 SHALL have ports q1_busy and q2_busy (output, 1 each), high when the queried register has a pending or in-flight write.
REQ-011 SHALL have ports rf_wr (output, 1), rf_a3 (output, 5) and rf_wd (output, 32), the registered drive of the single register-file write port.
REQ-012 SHALL have port sb_err, output, 1, a sticky flag set when port 1 writes a register that is not reserved.

Function
REQ-013 SHALL define a transfer on port n as wbn_vld && wbn_rdy in the same cycle.
REQ-014 SHALL drive, when starve < STARVE_MAX: wb0_rdy = 1 and wb1_rdy = !wb0_vld.
REQ-015 SHALL drive, when starve == STARVE_MAX: wb1_rdy = 1 and wb0_rdy = !wb1_vld.
REQ-016 SHALL drive the ready outputs combinationally from the current vld and starve state, so that at most one transfer occurs per cycle.
REQ-017 SHALL update the 4-bit starve counter as follows: +1 (saturating at STARVE_MAX) when wb1_vld && !wb1_rdy, cleared to 0 on a port-1 transfer or when wb1_vld is low.
REQ-018 SHALL, on a transfer, load rf_a3/rf_wd from the winning port at the next edge and set rf_wr = 1 for that one cycle (latency 1).
REQ-019 SHALL set rf_wr = 0 and hold rf_a3/rf_wd when no transfer occurs.
REQ-020 SHALL accept a transfer to register 0 normally, except that rf_wr stays 0 and rf_a3/rf_wd are not updated.
REQ-021 SHALL keep a 32-bit pending mask pend, where bit 0 is always 0.
REQ-022 SHALL set pend[rsv_reg] on rsv_vld when rsv_reg != 0; reserving an already-pending register leaves it set.
REQ-023 SHALL clear pend[wb1_reg] on a port-1 transfer.
REQ-024 SHALL let a set win when a set and a clear target the same register in the same cycle.
REQ-025 SHALL leave pend unaffected by port-0 transfers.
REQ-026 SHALL compute qn_busy = (qn_reg != 0) && (pend[qn_reg] || (rf_wr && rf_a3 == qn_reg)), combinationally.
REQ-027 SHALL set sb_err on a port-1 transfer with wb1_reg != 0 and pend[wb1_reg] == 0, and hold it until reset; the write still proceeds.

Reset
REQ-028 SHALL, while rst is high, force rf_wr = 0, rf_a3 = 0, rf_wd = 0, pend = 0, starve = 0 and sb_err = 0, immediately and independent of clk.
REQ-029 SHALL discard any transfer presented in the cycle rst deasserts (no rf_wr afterward), and SHALL clear all reservations on a mid-operation reset.

Structure
REQ-030 SHALL take REG_W = 5, DATA_W = 32 and NREG = 32 from shared package rf_pkg, which the register-file and pipeline blocks also use.
REQ-031 SHALL implement the pending mask, set/clear priority, busy lookup and sb_err in one sub-module, rf_scoreboard; arbitration and the output register stay in the top level.

Verification
REQ-032 SHALL cover: wb0 (r5, 0x11) and wb1 (r6, 0x22) both valid for 1 cycle -> r5 written in cycle +1, wb1 waits, r6 written in cycle +2.
REQ-033 SHALL cover: wb0 valid every cycle, wb1 valid on r7 (reserved) -> wb1 granted on the 5th cycle (STARVE_MAX = 4), rf_wr with rf_a3 = 7 one cycle later, starve returns to 0.
REQ-034 SHALL cover: rsv r9, q1_reg = 9 -> q1_busy = 1 until the cycle after the wb1 r9 write, then 0; q2_reg = 0 -> q2_busy always 0.
REQ-035 SHALL cover: wb0 transfer to r0 with data 0xFFFFFFFF -> wb0_rdy = 1, rf_wr stays 0, rf_a3/rf_wd unchanged.
REQ-036 SHALL cover: same-cycle rsv r3 and wb1 write r3 -> pend[3] remains 1 and sb_err stays 0; a wb1 write to unreserved r4 -> sb_err = 1 sticky.
REQ-037 SHALL cover: async rst pulse mid-edge while pend != 0 and rf_wr = 1 -> all outputs 0 immediately, q1_busy = 0 for any register.
